// File: rtl/gf_inv_seq.sv
// gf_inv_seq: sequential GF(2^m) inverter (binary extended Euclid), one micro-step per clock.
module gf_inv_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_GF     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [$clog2(DATA_WIDTH):0] polyn_grade,
    input  logic [DATA_WIDTH:0]         polyn_red_in,
    input  logic [DATA_WIDTH-1:0]       a,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [DATA_WIDTH-1:0]       out
);
    localparam int MW  = $clog2(DATA_WIDTH) + 1;
    localparam int WDW = $clog2(4 * MAX_GF + 6);
    localparam logic [DATA_WIDTH:0] ONE = 1;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FIN} state_t;
    state_t r_state, w_next;
    logic [MW-1:0]         r_m;
    logic [DATA_WIDTH:0]   r_f, r_u, r_v;
    logic [DATA_WIDTH-1:0] r_a, r_g1, r_g2, r_res, r_out;
    logic [WDW-1:0]        r_wd;
    logic                  r_err_pend, r_err, r_done;
    logic [DATA_WIDTH-1:0] w_amask;
    logic [DATA_WIDTH:0]   w_fmask;
    logic [WDW-1:0]        w_wd_lim;
    logic                  w_req_bad, w_u_one, w_v_one, w_wd_exp, w_u_gt;
    function automatic int f_deg(input logic [DATA_WIDTH:0] x);
        f_deg = 0;
        for (int i = 0; i <= DATA_WIDTH; i++)
            if (x[i]) f_deg = i;
    endfunction
    // Exact division by x in the field: add f first when g is odd.
    function automatic logic [DATA_WIDTH-1:0] f_half(input logic [DATA_WIDTH-1:0] g,
                                                     input logic [DATA_WIDTH:0] f);
        logic [DATA_WIDTH:0] t;
        t = g[0] ? ({1'b0, g} ^ f) : {1'b0, g};
        f_half = t[DATA_WIDTH:1];
    endfunction
    always_comb begin
        w_amask = '0;
        w_fmask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) w_amask[i] = i < int'(polyn_grade);
        for (int i = 0; i <= DATA_WIDTH; i++) w_fmask[i] = i <= int'(polyn_grade);
    end
    assign w_req_bad = int'(polyn_grade) < 2 || int'(polyn_grade) > MAX_GF || (a & w_amask) == '0;
    assign w_u_one   = r_u == ONE;
    assign w_v_one   = r_v == ONE;
    assign w_u_gt    = f_deg(r_u) > f_deg(r_v);
    assign w_wd_lim  = WDW'(4 * int'(r_m) + 4);
    assign w_wd_exp  = r_wd >= w_wd_lim;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? (w_req_bad ? S_FIN : S_LOAD) : S_IDLE;
            S_LOAD:  w_next = S_RUN;
            S_RUN:   w_next = (w_u_one || w_v_one || w_wd_exp) ? S_FIN : S_RUN;
            default: w_next = S_IDLE;
        endcase
    end
    always_comb begin
        busy = r_state != S_IDLE;
        done = r_done;
        err  = r_err;
        out  = r_out;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m        <= '0;
            r_f        <= '0;
            r_a        <= '0;
            r_u        <= '0;
            r_v        <= '0;
            r_g1       <= '0;
            r_g2       <= '0;
            r_res      <= '0;
            r_out      <= '0;
            r_wd       <= '0;
            r_err_pend <= 1'b0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= r_state == S_FIN;
            case (r_state)
                S_IDLE: if (start) begin
                    r_m        <= polyn_grade;
                    r_f        <= polyn_red_in & w_fmask;
                    r_a        <= a & w_amask;
                    r_err_pend <= w_req_bad;
                end
                S_LOAD: begin
                    r_u   <= {1'b0, r_a};
                    r_v   <= r_f;
                    r_g1  <= DATA_WIDTH'(1);
                    r_g2  <= '0;
                    r_res <= '0;
                    r_wd  <= '0;
                end
                S_RUN: begin
                    r_wd <= r_wd + 1'b1;
                    if (w_u_one) r_res <= r_g1;
                    else if (w_v_one) r_res <= r_g2;
                    else if (w_wd_exp) r_err_pend <= 1'b1;
                    else if (!r_u[0]) begin
                        r_u  <= r_u >> 1;
                        r_g1 <= f_half(r_g1, r_f);
                    end else if (!r_v[0]) begin
                        r_v  <= r_v >> 1;
                        r_g2 <= f_half(r_g2, r_f);
                    end else if (w_u_gt) begin
                        r_u  <= r_u ^ r_v;
                        r_g1 <= r_g1 ^ r_g2;
                    end else begin
                        r_v  <= r_v ^ r_u;
                        r_g2 <= r_g2 ^ r_g1;
                    end
                end
                default: begin
                    r_out <= r_err_pend ? '0 : r_res;
                    r_err <= r_err_pend;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gf_inv_seq.sv
// tb_gf_inv_seq: directed and random checks of gf_inv_seq against a field-arithmetic reference.
module tb_gf_inv_seq;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [5:0]  polyn_grade = '0;
    logic [32:0] polyn_red_in = '0;
    logic [31:0] a = '0;
    logic        busy, done, err;
    logic [31:0] out;
    int tests = 0, fails = 0;
    int ftab [17] = '{0, 0, 7, 11, 19, 37, 67, 131, 285, 529, 1033, 2053, 4179, 8219, 17475, 32771, 69643};
    always #5 clk = ~clk;
    gf_inv_seq #(.DATA_WIDTH(32), .MAX_GF(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .polyn_grade(polyn_grade),
        .polyn_red_in(polyn_red_in), .a(a), .busy(busy), .done(done), .err(err), .out(out)
    );
    function automatic int gmul(input int x, input int y, input int m, input int f);
        int r = 0;
        for (int i = 0; i < m; i++) begin
            if ((y >> i) & 1) r ^= x;
            x <<= 1;
            if ((x >> m) & 1) x ^= f;
        end
        return r;
    endfunction
    // a^(2^m-2) is the inverse in GF(2^m)
    function automatic int ginv(input int x, input int m, input int f);
        int r = 1, b = x, e = (1 << m) - 2;
        while (e > 0) begin
            if (e & 1) r = gmul(r, b, m, f);
            b = gmul(b, b, m, f);
            e >>= 1;
        end
        return r;
    endfunction
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic launch(input int m, input int f, input logic [31:0] av);
        polyn_grade  = 6'(m);
        polyn_red_in = 33'(f);
        a            = av;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic wait_done(output int lat, output int nbusy);
        lat = 1;
        nbusy = 0;
        while (done !== 1'b1 && lat < 300) begin
            if (busy !== 1'b1) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic run_op(input string tag, input int m, input int f, input logic [31:0] av,
                          output logic [31:0] o, output logic e, output int lat);
        int nb;
        @(negedge clk);
        launch(m, f, av);
        wait_done(lat, nb);
        o = out;
        e = err;
        chk({tag, "_done"}, 64'(done), 1);
        chk({tag, "_busy"}, 64'(nb), 0);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(done), 0);
    endtask
    initial begin
        #5_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        logic [31:0] o, prev;
        logic e;
        int lat, nb, m, av, cnt;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_out", 64'(out), 0);
        rst_n = 1'b1;
        run_op("m4a2", 4, 19, 2, o, e, lat);
        chk("m4a2_out", 64'(o), 9);
        chk("m4a2_err", 64'(e), 0);
        run_op("m4a1", 4, 19, 1, o, e, lat);
        chk("m4a1_out", 64'(o), 1);
        chk("m4a1_lat", 64'(lat), 4);
        run_op("m8a2", 8, 285, 2, o, e, lat);
        chk("m8a2_out", 64'(o), 142);
        chk("m8a2_lat", 64'(lat <= 35), 1);
        run_op("m3a3", 3, 11, 3, o, e, lat);
        chk("m3a3_out", 64'(o), 6);
        chk("m3a3_lat", 64'(lat <= 15), 1);
        run_op("a0", 8, 285, 0, o, e, lat);
        chk("a0_lat", 64'(lat), 2);
        chk("a0_err", 64'(e), 1);
        chk("a0_out", 64'(o), 0);
        run_op("m1", 1, 3, 1, o, e, lat);
        chk("m1_err", 64'(e), 1);
        chk("m1_lat", 64'(lat), 2);
        run_op("m17", 17, (1 << 17) | 9, 1, o, e, lat);
        chk("m17_err", 64'(e), 1);
        chk("m17_out", 64'(o), 0);
        run_op("mask", 8, 285, 32'h1F2, o, e, lat);
        chk("mask_out", 64'(o), 64'(ginv(32'hF2, 8, 285)));
        chk("mask_err", 64'(e), 0);
        run_op("wdog", 4, 17, 3, o, e, lat);
        chk("wdog_err", 64'(e), 1);
        chk("wdog_out", 64'(o), 0);
        for (int mm = 2; mm <= 8; mm++)
            for (int x = 1; x < (1 << mm); x++) begin
                run_op("exh", mm, ftab[mm], 32'(x), o, e, lat);
                chk("exh_out", 64'(o), 64'(ginv(x, mm, ftab[mm])));
                chk("exh_prod", 64'(gmul(x, int'(o), mm, ftab[mm])), 1);
                chk("exh_err", 64'(e), 0);
                chk("exh_lat", 64'(lat <= 4 * mm + 3), 1);
            end
        for (int k = 0; k < 400; k++) begin
            m  = int'($urandom_range(9, 16));
            av = int'($urandom_range(1, (1 << m) - 1));
            run_op("rnd", m, ftab[m], 32'(av) | ($urandom << m), o, e, lat);
            chk("rnd_out", 64'(o), 64'(ginv(av, m, ftab[m])));
            chk("rnd_prod", 64'(gmul(av, int'(o), m, ftab[m])), 1);
            chk("rnd_err", 64'(e), 0);
            chk("rnd_lat", 64'(lat <= 4 * m + 3), 1);
        end
        prev = out;
        @(negedge clk);
        launch(8, 285, 2);
        repeat (2) @(negedge clk);
        chk("busy_start_busy", 64'(busy), 1);
        launch(8, 285, 3);
        chk("busy_start_hold", 64'(out), 64'(prev));
        wait_done(lat, nb);
        chk("busy_start_out", 64'(out), 142);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("busy_start_nodone", 64'(cnt), 0);
        launch(4, 19, 2);
        wait_done(lat, nb);
        chk("b2b_first", 64'(out), 9);
        launch(4, 19, 3);
        wait_done(lat, nb);
        chk("b2b_done", 64'(done), 1);
        chk("b2b_second", 64'(out), 64'(ginv(3, 4, 19)));
        chk("b2b_busy", 64'(nb), 0);
        @(negedge clk);
        launch(16, ftab[16], 32'h1234);
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_done", 64'(done), 0);
        chk("mid_rst_err", 64'(err), 0);
        chk("mid_rst_out", 64'(out), 0);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("mid_rst_nodone", 64'(cnt), 0);
        rst_n = 1'b1;
        run_op("post_rst", 16, ftab[16], 32'h1234, o, e, lat);
        chk("post_rst_out", 64'(o), 64'(ginv(32'h1234, 16, ftab[16])));
        chk("post_rst_err", 64'(e), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
